result_stage_pipe: RTL and testbench
====================================

# result_stage_pipe

Parametrised multi-lane result staging pipeline for the SPU execute back-end, following the fixed two-lane, 7-stage even/odd packed-stage wrapper. Each lane carries issued results through DEPTH registered stages with destination, unit-ID and latency tags, and writes each result back to the register file at the final stage. The pipeline forwards a result once its latency has elapsed, raises a hazard flag for operands still in flight, and supports a flush that squashes uncompleted work.

## Interface
Parameters:
- LANES, 2, number of issue lanes (lane 0 = even, lane 1 = odd)
- DEPTH, 7, stage count; writeback stage = DEPTH
- DATA_W, 128, result width
- ADDR_W, 7, register address width
- UID_W, 3, functional-unit ID width
- LAT_W, 4, latency field width
- NRD, 6, forwarding query ports

Ports (lane/port i occupies slice i of each packed vector):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  LANES  issue valid per lane
- in_wr  in  LANES  result writes a register (reg_wr)
- in_dst  in  LANES*ADDR_W  destination register
- in_uid  in  LANES*UID_W  unit ID, carried only
- in_lat  in  LANES*LAT_W  result latency in cycles
- in_data  in  LANES*DATA_W  result value
- flush  in  1  squash non-ready entries and this cycle's issue
- rd_addr  in  NRD*ADDR_W  forwarding query addresses
- fwd_hit  out  NRD  ready in-flight producer found
- fwd_data  out  NRD*DATA_W  forwarded value, 0 when no hit
- hazard  out  NRD  a non-ready producer is younger than any ready match
- wb_valid  out  LANES  writeback strobe
- wb_addr  out  LANES*ADDR_W  writeback register
- wb_data  out  LANES*DATA_W  writeback value
- wb_uid  out  LANES*UID_W  writeback unit ID
- occupancy  out  LANES*$clog2(DEPTH+1)  live entries per lane

## Operation
- Each lane is a shift register of DEPTH entries. An entry holds {valid, wr, dst, uid, lat, age-ready flag, data}. Stage 1 loads from the inputs and stage k loads from stage k-1 every cycle. There is no stall.
- Effective latency is clamp(in_lat, 1, DEPTH): 0 becomes 1 and any value above DEPTH becomes DEPTH. The entry in stage k is ready when k ≥ effective latency.
- An entry is live when valid=1 and wr=1. Entries with wr=0 still propagate but never match, forward or write back.
- Forwarding for port p: among live entries in all lanes and all stages where dst == rd_addr[p], select the youngest, meaning the lowest stage index. Within one stage, the higher lane index wins.
  - If the selected entry is ready: fwd_hit=1 and fwd_data=its data.
  - If it is not ready: hazard=1, fwd_hit=0, fwd_data=0.
  - Query addresses are combinational to the outputs.
- Writeback: wb_valid[i] = live(stage DEPTH of lane i). wb_addr, wb_data and wb_uid come from that stage. They are 0 when wb_valid is 0.
- Flush: on an edge with flush=1, every non-ready entry gets valid cleared as it shifts, and stage 1 loads valid=0 regardless of in_valid. Ready entries continue to writeback.
- occupancy[i] is a registered up/down counter of valid entries in lane i. It increments on accepted issue and decrements on an entry leaving stage DEPTH or being flushed. It is recomputed each cycle and never exceeds DEPTH.
- Two lanes issuing the same in_dst in one cycle is legal. Lane-priority ordering applies, and both lanes write back.

## Timing
- Reset (rst=0, asynchronous): all valid bits 0, occupancy 0, wb_valid 0, wb_* 0, fwd_hit 0, hazard 0. Deassertion is synchronised externally, so the first active edge follows it.
- Issue at edge E puts the entry in stage 1 after E. It is in stage k after E+k-1 and on the wb_* outputs in the cycle after edge E+DEPTH-1. This gives a writeback latency of DEPTH cycles from issue.
- An entry issued at E with effective latency L first forwards (fwd_hit) in the cycle after edge E+L-1. It reports hazard in the cycles before that.
- An issue and a writeback for the same address in one cycle: the writeback is visible as a ready stage-DEPTH match. The new issue only matches after its own edge.
- Reset asserted mid-operation clears everything immediately. In-flight writebacks are lost.

## Test plan
- Reset, then issue lane 0 dst=5, lat=4, data=0xA5…A5, wr=1 -> rd_addr=5 shows hazard for stages 1–3 and fwd_hit with 0xA5…A5 from stage 4. wb_valid[0] pulses once with addr 5 exactly 7 cycles after issue. occupancy[0] goes 1 then 0.
- Lane 0 dst=2 lat=6 and lane 1 dst=2 lat=2 issued together -> from stage 2 the query forwards lane 1 data. Both lanes write back at cycle 7: lane 0 then lane 1, same cycle.
- Issue dst=9 lat=2 (data 0x11), then the next cycle dst=9 lat=6 (data 0x22) -> query reports hazard, not the older 0x11, while the younger entry is non-ready. It returns 0x22 once ready.
- Fill lane 1 with 7 consecutive lat=3 issues, then assert flush -> entries in stages 1–2 are squashed and the flush-cycle issue is dropped. Stages ≥3 still write back. occupancy matches the surviving count.
- in_lat=0 and in_lat=15 -> behave as latency 1 and 7 respectively. An entry with wr=0 never raises fwd_hit, hazard or wb_valid.
- Assert rst low for a fraction of a cycle with 5 entries in flight -> all outputs go to 0 immediately and no wb_valid follows.

Source files
------------

// File: rtl/result_stage_pipe.sv
// Multi-lane result staging pipeline: per-lane shift registers carrying tagged results to
// writeback, with latency-aware forwarding, in-flight hazard detection and flush.
module result_stage_pipe #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned UID_W  = 3,
  parameter int unsigned LAT_W  = 4,
  parameter int unsigned NRD    = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LANES-1:0]                  in_valid,
  input  logic [LANES-1:0]                  in_wr,
  input  logic [LANES*ADDR_W-1:0]           in_dst,
  input  logic [LANES*UID_W-1:0]            in_uid,
  input  logic [LANES*LAT_W-1:0]            in_lat,
  input  logic [LANES*DATA_W-1:0]           in_data,
  input  logic                              flush,
  input  logic [NRD*ADDR_W-1:0]             rd_addr,
  output logic [NRD-1:0]                    fwd_hit,
  output logic [NRD*DATA_W-1:0]             fwd_data,
  output logic [NRD-1:0]                    hazard,
  output logic [LANES-1:0]                  wb_valid,
  output logic [LANES*ADDR_W-1:0]           wb_addr,
  output logic [LANES*DATA_W-1:0]           wb_data,
  output logic [LANES*UID_W-1:0]            wb_uid,
  output logic [LANES*$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Index [l][s] is lane l, stage s+1.
  logic              valid_q [LANES][DEPTH];
  logic              valid_d [LANES][DEPTH];
  logic              wr_q    [LANES][DEPTH];
  logic              wr_d    [LANES][DEPTH];
  logic [ADDR_W-1:0] dst_q   [LANES][DEPTH];
  logic [ADDR_W-1:0] dst_d   [LANES][DEPTH];
  logic [UID_W-1:0]  uid_q   [LANES][DEPTH];
  logic [UID_W-1:0]  uid_d   [LANES][DEPTH];
  logic [CntW-1:0]   lat_q   [LANES][DEPTH];
  logic [CntW-1:0]   lat_d   [LANES][DEPTH];
  logic [DATA_W-1:0] data_q  [LANES][DEPTH];
  logic [DATA_W-1:0] data_d  [LANES][DEPTH];
  logic [CntW-1:0]   occ_q   [LANES];
  logic [CntW-1:0]   occ_d   [LANES];

  logic              ready   [LANES][DEPTH];
  logic              live    [LANES][DEPTH];

  logic              sel_vld  [NRD];
  logic              sel_rdy  [NRD];
  logic [DATA_W-1:0] sel_data [NRD];

  // Clamp the requested latency into 1..DEPTH.
  function automatic logic [CntW-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    logic [CntW-1:0] res;
    if (lat == '0) begin
      res = CntW'(1);
    end else if (32'(lat) > DEPTH) begin
      res = CntW'(DEPTH);
    end else begin
      res = CntW'(lat);
    end
    return res;
  endfunction

  // An entry in stage k is ready once k has reached its effective latency.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        ready[l][s] = int'(lat_q[l][s]) <= s + 1;
        live[l][s]  = valid_q[l][s] & wr_q[l][s];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      valid_d[l][0] = in_valid[l] & ~flush;
      wr_d[l][0]    = in_wr[l];
      dst_d[l][0]   = in_dst[l*ADDR_W +: ADDR_W];
      uid_d[l][0]   = in_uid[l*UID_W +: UID_W];
      lat_d[l][0]   = eff_lat(in_lat[l*LAT_W +: LAT_W]);
      data_d[l][0]  = in_data[l*DATA_W +: DATA_W];
      for (int s = 1; s < DEPTH; s++) begin
        // Flush squashes only entries whose result is not yet ready.
        valid_d[l][s] = valid_q[l][s-1] & ~(flush & ~ready[l][s-1]);
        wr_d[l][s]    = wr_q[l][s-1];
        dst_d[l][s]   = dst_q[l][s-1];
        uid_d[l][s]   = uid_q[l][s-1];
        lat_d[l][s]   = lat_q[l][s-1];
        data_d[l][s]  = data_q[l][s-1];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      occ_d[l] = occ_q[l];
      if (in_valid[l] && !flush) begin
        occ_d[l] = occ_d[l] + CntW'(1);
      end
      if (valid_q[l][DEPTH-1]) begin
        occ_d[l] = occ_d[l] - CntW'(1);
      end
      for (int s = 0; s < DEPTH - 1; s++) begin
        if (flush && valid_q[l][s] && !ready[l][s]) begin
          occ_d[l] = occ_d[l] - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) begin
        occ_q[l] <= '0;
        for (int s = 0; s < DEPTH; s++) begin
          valid_q[l][s] <= 1'b0;
          wr_q[l][s]    <= 1'b0;
          dst_q[l][s]   <= '0;
          uid_q[l][s]   <= '0;
          lat_q[l][s]   <= '0;
          data_q[l][s]  <= '0;
        end
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        occ_q[l] <= occ_d[l];
        for (int s = 0; s < DEPTH; s++) begin
          valid_q[l][s] <= valid_d[l][s];
          wr_q[l][s]    <= wr_d[l][s];
          dst_q[l][s]   <= dst_d[l][s];
          uid_q[l][s]   <= uid_d[l][s];
          lat_q[l][s]   <= lat_d[l][s];
          data_q[l][s]  <= data_d[l][s];
        end
      end
    end
  end

  // Scan oldest to youngest, lower lane first, so the last match is the winner.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      sel_vld[p]  = 1'b0;
      sel_rdy[p]  = 1'b0;
      sel_data[p] = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (live[l][s] && dst_q[l][s] == rd_addr[p*ADDR_W +: ADDR_W]) begin
            sel_vld[p]  = 1'b1;
            sel_rdy[p]  = ready[l][s];
            sel_data[p] = data_q[l][s];
          end
        end
      end
    end
  end

  always_comb begin
    fwd_hit  = '0;
    hazard   = '0;
    fwd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      fwd_hit[p] = sel_vld[p] & sel_rdy[p];
      hazard[p]  = sel_vld[p] & ~sel_rdy[p];
      if (sel_vld[p] && sel_rdy[p]) begin
        fwd_data[p*DATA_W +: DATA_W] = sel_data[p];
      end
    end
  end

  always_comb begin
    wb_valid  = '0;
    wb_addr   = '0;
    wb_data   = '0;
    wb_uid    = '0;
    occupancy = '0;
    for (int l = 0; l < LANES; l++) begin
      wb_valid[l] = live[l][DEPTH-1];
      if (live[l][DEPTH-1]) begin
        wb_addr[l*ADDR_W +: ADDR_W] = dst_q[l][DEPTH-1];
        wb_data[l*DATA_W +: DATA_W] = data_q[l][DEPTH-1];
        wb_uid[l*UID_W +: UID_W]    = uid_q[l][DEPTH-1];
      end
      occupancy[l*CntW +: CntW] = occ_q[l];
    end
  end

endmodule

// File: tb/tb_result_stage_pipe.sv
// Randomized bench for result_stage_pipe: a list-based reference model of in-flight results
// drives forwarding/occupancy expectations, and a writeback scoreboard is checked by a monitor.
`timescale 1ns/1ps
module tb_result_stage_pipe;
  localparam int LANES  = 2;
  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int UID_W  = 3;
  localparam int LAT_W  = 4;
  localparam int NRD    = 6;
  localparam int CW     = $clog2(DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [LANES-1:0]          in_valid;
  logic [LANES-1:0]          in_wr;
  logic [LANES*ADDR_W-1:0]   in_dst;
  logic [LANES*UID_W-1:0]    in_uid;
  logic [LANES*LAT_W-1:0]    in_lat;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      flush;
  logic [NRD*ADDR_W-1:0]     rd_addr;
  logic [NRD-1:0]            fwd_hit;
  logic [NRD*DATA_W-1:0]     fwd_data;
  logic [NRD-1:0]            hazard;
  logic [LANES-1:0]          wb_valid;
  logic [LANES*ADDR_W-1:0]   wb_addr;
  logic [LANES*DATA_W-1:0]   wb_data;
  logic [LANES*UID_W-1:0]    wb_uid;
  logic [LANES*CW-1:0]       occupancy;

  always #5 clk = ~clk;

  result_stage_pipe #(
    .LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .UID_W(UID_W), .LAT_W(LAT_W), .NRD(NRD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wr(in_wr), .in_dst(in_dst),
    .in_uid(in_uid), .in_lat(in_lat), .in_data(in_data), .flush(flush),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .hazard(hazard),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_uid(wb_uid),
    .occupancy(occupancy)
  );

  typedef struct {
    int                lane;
    bit                wr;
    logic [ADDR_W-1:0] dst;
    logic [UID_W-1:0]  uid;
    int                lat;
    logic [DATA_W-1:0] data;
    int                issue;
  } ent_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [UID_W-1:0]  uid;
    int                due;
    int                issue;
    int                lat;
  } wb_t;

  ent_t inflight[$];
  wb_t  exp_wb0[$];
  wb_t  exp_wb1[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Model the edge: age everything one stage, apply flush, then accept this cycle's issue.
  // An entry issued at edge n sits in stage (cyc - n + 1) after edge cyc.
  function automatic void model_edge();
    ent_t keep[$];
    wb_t  k0[$];
    wb_t  k1[$];
    int   st;
    int   l_in;
    ent_t e;
    wb_t  w;
    cyc++;
    foreach (inflight[i]) begin
      st = cyc - inflight[i].issue;
      if (st >= DEPTH) continue;
      if (flush && st < inflight[i].lat) continue;
      keep.push_back(inflight[i]);
    end
    inflight = keep;
    if (flush) begin
      foreach (exp_wb0[i]) if (cyc - exp_wb0[i].issue >= exp_wb0[i].lat) k0.push_back(exp_wb0[i]);
      foreach (exp_wb1[i]) if (cyc - exp_wb1[i].issue >= exp_wb1[i].lat) k1.push_back(exp_wb1[i]);
      exp_wb0 = k0;
      exp_wb1 = k1;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (in_valid[l]) begin
          l_in    = int'(in_lat[l*LAT_W +: LAT_W]);
          e.lane  = l;
          e.wr    = in_wr[l];
          e.dst   = in_dst[l*ADDR_W +: ADDR_W];
          e.uid   = in_uid[l*UID_W +: UID_W];
          e.lat   = (l_in == 0) ? 1 : ((l_in > DEPTH) ? DEPTH : l_in);
          e.data  = in_data[l*DATA_W +: DATA_W];
          e.issue = cyc;
          inflight.push_back(e);
          if (e.wr) begin
            w.addr  = e.dst;
            w.data  = e.data;
            w.uid   = e.uid;
            w.due   = cyc + DEPTH - 1;
            w.issue = cyc;
            w.lat   = e.lat;
            if (l == 0) exp_wb0.push_back(w);
            else        exp_wb1.push_back(w);
          end
        end
      end
    end
  endfunction

  function automatic void model_query(input logic [ADDR_W-1:0] a, output bit hit,
                                      output bit haz, output logic [DATA_W-1:0] d);
    int best_st   = DEPTH + 1;
    int best_lane = -1;
    int bi        = -1;
    int st;
    hit = 1'b0;
    haz = 1'b0;
    d   = '0;
    foreach (inflight[i]) begin
      if (inflight[i].wr && inflight[i].dst == a) begin
        st = cyc - inflight[i].issue + 1;
        if (st < best_st || (st == best_st && inflight[i].lane > best_lane)) begin
          best_st   = st;
          best_lane = inflight[i].lane;
          bi        = i;
        end
      end
    end
    if (bi >= 0) begin
      if (best_st >= inflight[bi].lat) begin
        hit = 1'b1;
        d   = inflight[bi].data;
      end else begin
        haz = 1'b1;
      end
    end
  endfunction

  function automatic void mon_lane(int l);
    wb_t q[$];
    wb_t e;
    if (l == 0) q = exp_wb0;
    else        q = exp_wb1;
    if (wb_valid[l]) begin
      if (q.size() == 0) begin
        check("wb_spurious", DATA_W'(wb_valid[l]), '0);
      end else begin
        e = q.pop_front();
        check("wb_cycle", DATA_W'(cyc), DATA_W'(e.due));
        check("wb_addr", DATA_W'(wb_addr[l*ADDR_W +: ADDR_W]), DATA_W'(e.addr));
        check("wb_data", wb_data[l*DATA_W +: DATA_W], e.data);
        check("wb_uid", DATA_W'(wb_uid[l*UID_W +: UID_W]), DATA_W'(e.uid));
      end
    end else begin
      if (q.size() != 0 && q[0].due <= cyc) begin
        check("wb_missing", DATA_W'(wb_valid[l]), DATA_W'(1));
        void'(q.pop_front());
      end
      check("wb_idle_data", wb_data[l*DATA_W +: DATA_W], '0);
      check("wb_idle_tag", DATA_W'({wb_addr[l*ADDR_W +: ADDR_W], wb_uid[l*UID_W +: UID_W]}), '0);
    end
    if (l == 0) exp_wb0 = q;
    else        exp_wb1 = q;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) mon_lane(l);
    end
  end

  function automatic logic [ADDR_W-1:0] pick_addr();
    if (inflight.size() > 0 && $urandom_range(0, 2) != 0)
      return inflight[$urandom_range(0, inflight.size() - 1)].dst;
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  task automatic check_cycle();
    bit                hit;
    bit                haz;
    logic [DATA_W-1:0] d;
    int                cnt;
    for (int p = 0; p < NRD; p++) rd_addr[p*ADDR_W +: ADDR_W] = pick_addr();
    #1;
    for (int p = 0; p < NRD; p++) begin
      model_query(rd_addr[p*ADDR_W +: ADDR_W], hit, haz, d);
      check("fwd_hit", DATA_W'(fwd_hit[p]), DATA_W'(hit));
      check("hazard", DATA_W'(hazard[p]), DATA_W'(haz));
      check("fwd_data", fwd_data[p*DATA_W +: DATA_W], d);
    end
    for (int l = 0; l < LANES; l++) begin
      cnt = 0;
      foreach (inflight[i]) if (inflight[i].lane == l) cnt++;
      check("occupancy", DATA_W'(occupancy[l*CW +: CW]), DATA_W'(cnt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    in_wr    = '0;
    in_dst   = '0;
    in_uid   = '0;
    in_lat   = '0;
    in_data  = '0;
    flush    = 1'b0;
  endtask

  task automatic set_lane(int l, bit wr, int dst, int lat, logic [DATA_W-1:0] data);
    in_valid[l]                  = 1'b1;
    in_wr[l]                     = wr;
    in_dst[l*ADDR_W +: ADDR_W]   = ADDR_W'(dst);
    in_uid[l*UID_W +: UID_W]     = UID_W'($urandom);
    in_lat[l*LAT_W +: LAT_W]     = LAT_W'(lat);
    in_data[l*DATA_W +: DATA_W]  = data;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    idle_inputs();
    repeat (DEPTH + 2) tick();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_wb_valid"}, DATA_W'(wb_valid), '0);
    check({tag, "_wb_data"}, DATA_W'(|wb_data), '0);
    check({tag, "_wb_tag"}, DATA_W'({wb_addr, wb_uid}), '0);
    check({tag, "_fwd_hit"}, DATA_W'(fwd_hit), '0);
    check({tag, "_hazard"}, DATA_W'(hazard), '0);
    check({tag, "_fwd_data"}, DATA_W'(|fwd_data), '0);
    check({tag, "_occupancy"}, DATA_W'(occupancy), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rd_addr = '0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int p = 0; p < NRD; p++) rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(p);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Single lane-0 result, latency 4.
    set_lane(0, 1'b1, 5, 4, {16{8'hA5}});
    tick();
    drain();

    // Same destination on both lanes in one cycle.
    set_lane(0, 1'b1, 2, 6, rnd_data());
    set_lane(1, 1'b1, 2, 2, rnd_data());
    tick();
    drain();

    // Younger non-ready producer hides an older ready one.
    set_lane(0, 1'b1, 9, 2, DATA_W'(128'h11));
    tick();
    idle_inputs();
    set_lane(0, 1'b1, 9, 6, DATA_W'(128'h22));
    tick();
    drain();

    // Fill lane 1, then flush with an issue in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      set_lane(1, 1'b1, 20 + i, 3, rnd_data());
      tick();
    end
    idle_inputs();
    set_lane(1, 1'b1, 40, 3, rnd_data());
    flush = 1'b1;
    tick();
    drain();

    // Latency clamping and non-writing entries.
    set_lane(0, 1'b1, 12, 0, rnd_data());
    set_lane(1, 1'b1, 13, 15, rnd_data());
    tick();
    idle_inputs();
    set_lane(0, 1'b0, 12, 3, rnd_data());
    set_lane(1, 1'b0, 14, 0, rnd_data());
    tick();
    drain();

    // Random traffic with occasional flushes.
    repeat (400) begin
      idle_inputs();
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 9) < 6)
          set_lane(l, ($urandom_range(0, 9) != 0), $urandom_range(0, 15),
                   $urandom_range(0, 15), rnd_data());
      end
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain();

    // Asynchronous reset with entries in flight.
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      set_lane(0, 1'b1, 30 + i, 2, rnd_data());
      tick();
    end
    idle_inputs();
    for (int p = 0; p < NRD; p++) rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(30 + (p % 5));
    #1 rst = 1'b0;
    #1;
    check_all_zero("midrst");
    inflight.delete();
    exp_wb0.delete();
    exp_wb1.delete();
    rst = 1'b1;
    repeat (DEPTH + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
